// File: rtl/csync_pkg.sv
// csync_pkg: shared state encoding, pulse types and default timing for the composite-sync sequencer.
`default_nettype none

package csync_pkg;

    localparam int DEF_LINE_CLKS = 766;
    localparam int DEF_HSYNC_W   = 56;
    localparam int DEF_EQ_W      = 28;
    localparam int DEF_SERR_W    = 327;
    localparam int DEF_EQ_LINES  = 3;
    localparam int DEF_VS_MAX    = 8;

    localparam logic [2:0] ST_UNLOCKED = 3'd0;
    localparam logic [2:0] ST_NORMAL   = 3'd1;
    localparam logic [2:0] ST_PRE_EQ   = 3'd2;
    localparam logic [2:0] ST_VSYNC    = 3'd3;
    localparam logic [2:0] ST_POST_EQ  = 3'd4;

    typedef enum logic [1:0] {
        PT_NONE  = 2'd0,
        PT_HSYNC = 2'd1,
        PT_EQ    = 2'd2,
        PT_SERR  = 2'd3
    } pulse_e;

    function automatic pulse_e pulse_for_state(input logic [2:0] st);
        pulse_e p;
        case (st)
            ST_UNLOCKED, ST_NORMAL: p = PT_HSYNC;
            ST_PRE_EQ, ST_POST_EQ:  p = PT_EQ;
            ST_VSYNC:               p = PT_SERR;
            default:                p = PT_NONE;
        endcase
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csync_pulse_shaper.sv
// csync_pulse_shaper: turns (pulse type, hcnt) into the registered active-low composite sync.
`default_nettype none

module csync_pulse_shaper
    import csync_pkg::*;
#(
    parameter int LINE_CLKS = DEF_LINE_CLKS,
    parameter int HSYNC_W   = DEF_HSYNC_W,
    parameter int EQ_W      = DEF_EQ_W,
    parameter int SERR_W    = DEF_SERR_W,
    parameter int HCW       = $clog2(LINE_CLKS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [HCW-1:0] hcnt,
    input  pulse_e         ptype,
    output logic           csync
);

    localparam int HALF = LINE_CLKS / 2;

    localparam logic [HCW-1:0] HS_END    = HCW'(HSYNC_W);
    localparam logic [HCW-1:0] EQ_END    = HCW'(EQ_W);
    localparam logic [HCW-1:0] SERR_END  = HCW'(SERR_W);
    localparam logic [HCW-1:0] HALF_BEG  = HCW'(HALF);
    localparam logic [HCW-1:0] HEQ_END   = HCW'(HALF + EQ_W);
    localparam logic [HCW-1:0] HSERR_END = HCW'(HALF + SERR_W);

    logic low;
    logic in_second_half;

    assign in_second_half = (hcnt >= HALF_BEG);

    always_comb begin
        low = 1'b0;
        case (ptype)
            PT_HSYNC: low = (hcnt < HS_END);
            PT_EQ:    low = (hcnt < EQ_END) || (in_second_half && (hcnt < HEQ_END));
            PT_SERR:  low = (hcnt < SERR_END) || (in_second_half && (hcnt < HSERR_END));
            default:  low = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csync <= 1'b1;
        end else begin
            csync <= ~low;
        end
    end

endmodule

`default_nettype wire

// File: rtl/csync_sequencer.sv
// csync_sequencer: line/frame timing, frame-length prediction and sync-state sequencing
// feeding the pulse shaper, realigned to the incoming active-low vsync.
`default_nettype none

module csync_sequencer
    import csync_pkg::*;
#(
    parameter int LINE_CLKS = DEF_LINE_CLKS,
    parameter int HSYNC_W   = DEF_HSYNC_W,
    parameter int EQ_W      = DEF_EQ_W,
    parameter int SERR_W    = DEF_SERR_W,
    parameter int EQ_LINES  = DEF_EQ_LINES,
    parameter int VS_MAX    = DEF_VS_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    output logic       csync,
    output logic       locked,
    output logic [9:0] frame_lines,
    output logic [2:0] state
);

    localparam int HCW = (LINE_CLKS > 1) ? $clog2(LINE_CLKS) : 1;

    localparam logic [HCW-1:0] HC_LAST   = HCW'(LINE_CLKS - 1);
    localparam logic [9:0]     MIN_LINES = 10'd16;
    localparam logic [9:0]     EQ_L      = 10'(EQ_LINES);
    localparam logic [9:0]     VS_LIM    = 10'(VS_MAX);
    localparam logic [3:0]     SEG_LAST  = 4'(EQ_LINES - 1);

    logic [HCW-1:0] hcnt;
    logic [9:0]     line_cnt;
    logic [3:0]     seg_cnt;
    logic           vs_q;
    logic           vs_done;
    logic           have_ref;

    logic           vs_fall;
    logic           vs_rise;
    logic           realign;
    logic           line_end;
    logic [9:0]     line_nxt;
    logic [9:0]     pre_line;
    logic           frame_overrun;
    pulse_e         ptype;

    assign vs_fall  = vs_q & ~vsync;
    assign vs_rise  = ~vs_q & vsync;
    assign realign  = vs_fall && (state != ST_VSYNC);
    assign line_end = (hcnt == HC_LAST);
    // Saturating increment doubles as the frame-length measurement on realign.
    assign line_nxt = (line_cnt == 10'h3FF) ? line_cnt : line_cnt + 10'd1;
    assign pre_line = frame_lines - EQ_L;
    assign frame_overrun = ({1'b0, line_nxt} == ({1'b0, frame_lines} + 11'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_UNLOCKED;
            hcnt        <= '0;
            line_cnt    <= '0;
            frame_lines <= '0;
            locked      <= 1'b0;
            vs_q        <= 1'b1;
            vs_done     <= 1'b0;
            have_ref    <= 1'b0;
            seg_cnt     <= '0;
        end else begin
            vs_q <= vsync;
            if (realign) begin
                hcnt     <= '0;
                line_cnt <= '0;
                state    <= ST_VSYNC;
                vs_done  <= 1'b0;
                have_ref <= 1'b1;
                // The very first edge after reset has nothing to be measured against.
                if (have_ref) begin
                    frame_lines <= line_nxt;
                    locked      <= (line_nxt == frame_lines) && (line_nxt >= MIN_LINES);
                end
            end else begin
                if (line_end) begin
                    hcnt     <= '0;
                    line_cnt <= line_nxt;
                end else begin
                    hcnt <= hcnt + HCW'(1);
                end

                case (state)
                    ST_NORMAL: begin
                        if (line_end && locked && (line_nxt == pre_line)) begin
                            state <= ST_PRE_EQ;
                        end
                    end
                    ST_PRE_EQ: begin
                        if (line_end && frame_overrun) begin
                            state  <= ST_UNLOCKED;
                            locked <= 1'b0;
                        end
                    end
                    ST_VSYNC: begin
                        if (vs_rise) begin
                            vs_done <= 1'b1;
                        end
                        if (line_end && (vs_done || vs_rise || (line_nxt >= VS_LIM))) begin
                            state   <= ST_POST_EQ;
                            seg_cnt <= '0;
                        end
                    end
                    ST_POST_EQ: begin
                        if (line_end) begin
                            if (seg_cnt == SEG_LAST) begin
                                state <= ST_NORMAL;
                            end else begin
                                seg_cnt <= seg_cnt + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The cycle that realigns emits no pulse, so a truncated line never leaves a stray edge.
    assign ptype = realign ? PT_NONE : pulse_for_state(state);

    csync_pulse_shaper #(
        .LINE_CLKS (LINE_CLKS),
        .HSYNC_W   (HSYNC_W),
        .EQ_W      (EQ_W),
        .SERR_W    (SERR_W),
        .HCW       (HCW)
    ) u_shaper (
        .clk   (clk),
        .rst   (rst),
        .hcnt  (hcnt),
        .ptype (ptype),
        .csync (csync)
    );

endmodule

`default_nettype wire

// File: tb/tb_csync_sequencer.sv
// tb_csync_sequencer: directed bench on a scaled timing set (40-clock lines, 24-line frames).
`default_nettype none

module tb_csync_sequencer;

    localparam int LC = 40;

    localparam logic [2:0] S_UNL  = 3'd0;
    localparam logic [2:0] S_NORM = 3'd1;
    localparam logic [2:0] S_PRE  = 3'd2;
    localparam logic [2:0] S_VS   = 3'd3;
    localparam logic [2:0] S_POST = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync;
    logic       csync;
    logic       locked;
    logic [9:0] frame_lines;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    csync_sequencer #(
        .LINE_CLKS (LC),
        .HSYNC_W   (4),
        .EQ_W      (2),
        .SERR_W    (17),
        .EQ_LINES  (3),
        .VS_MAX    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vsync),
        .csync       (csync),
        .locked      (locked),
        .frame_lines (frame_lines),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_low(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (csync === 1'b0) lows++;
        end
    endtask

    task automatic vs_fall_now();
        vsync = 1'b0;
        @(negedge clk);
    endtask

    // Rest of a frame after the falling edge: vsync low for 3 lines total, then high.
    task automatic frame_rest(input int lines, output int lows, output int lows0,
                              output logic [2:0] st_a, output logic [2:0] st_b,
                              output logic [2:0] st_c, output logic [2:0] st_pre,
                              output logic cs_mid);
        lows = 0;
        lows0 = 0;
        for (int j = 1; j < lines * LC; j++) begin
            if (j == 3 * LC) vsync = 1'b1;
            @(negedge clk);
            if (csync === 1'b0) begin
                lows++;
                if (j <= LC) lows0++;
            end
            if (j == 100) st_a = state;
            if (j == 3 * LC) st_b = state;
            if (j == 6 * LC) st_c = state;
            if (j == (lines - 3) * LC + 5) st_pre = state;
            if (j == (lines - 3) * LC + 21) cs_mid = csync;
        end
    endtask

    int lows, lows0;
    logic [2:0] st_a, st_b, st_c, st_pre;
    logic cs_mid, cs_first, cs5;

    initial begin
        rst   = 1'b1;
        vsync = 1'b1;
        step(3);
        chk("rst_csync", csync, 1);
        chk("rst_state", state, S_UNL);
        chk("rst_locked", locked, 0);
        chk("rst_frame", frame_lines, 0);

        // Two free-running lines: 4-clock hsync at the start of each.
        rst = 1'b0;
        lows = 0;
        for (int k = 1; k <= 2 * LC; k++) begin
            @(negedge clk);
            if (csync === 1'b0) lows++;
            if (k == 1) cs_first = csync;
            if (k == 5) cs5 = csync;
        end
        chk("unl_first_low", cs_first, 0);
        chk("unl_hs_end", cs5, 1);
        chk("unl_lows_2lines", lows, 8);
        chk("unl_state", state, S_UNL);
        chk("unl_locked", locked, 0);
        step(13);

        // Frame 1: first edge, measurement discarded, mid-line pulse abandoned.
        vs_fall_now();
        chk("f1_state", state, S_VS);
        chk("f1_abandon", csync, 1);
        chk("f1_frame", frame_lines, 0);
        chk("f1_locked", locked, 0);
        frame_rest(24, lows, lows0, st_a, st_b, st_c, st_pre, cs_mid);
        chk("f1_serr_lows", lows0, 34);
        chk("f1_st_vsync", st_a, S_VS);
        chk("f1_st_post", st_b, S_POST);
        chk("f1_st_norm", st_c, S_NORM);
        chk("f1_no_pre", st_pre, S_NORM);
        chk("f1_mid", cs_mid, 1);
        chk("f1_lows", lows, 186);

        // Frame 2: first real measurement, nothing to match yet.
        vs_fall_now();
        chk("f2_frame", frame_lines, 24);
        chk("f2_locked", locked, 0);
        frame_rest(24, lows, lows0, st_a, st_b, st_c, st_pre, cs_mid);
        chk("f2_no_pre", st_pre, S_NORM);

        // Frame 3: matching measurement locks; pre-equalization from line 21.
        vs_fall_now();
        chk("f3_frame", frame_lines, 24);
        chk("f3_locked", locked, 1);
        frame_rest(24, lows, lows0, st_a, st_b, st_c, st_pre, cs_mid);
        chk("f3_pre", st_pre, S_PRE);
        chk("f3_eq_half", cs_mid, 0);
        chk("f3_lows", lows, 186);
        chk("f3_post", st_b, S_POST);

        // Frame 4: still locked; vsync arrives 5 lines early.
        vs_fall_now();
        chk("f4_locked", locked, 1);
        frame_rest(19, lows, lows0, st_a, st_b, st_c, st_pre, cs_mid);
        chk("f4_st_line16", st_pre, S_NORM);
        chk("f4_lows", lows, 166);
        chk("f4_before_fall", state, S_NORM);

        // Early edge realigns at once and breaks the lock.
        vs_fall_now();
        chk("f5_state", state, S_VS);
        chk("f5_frame", frame_lines, 19);
        chk("f5_locked", locked, 0);
        frame_rest(24, lows, lows0, st_a, st_b, st_c, st_pre, cs_mid);
        chk("f5_no_pre", st_pre, S_NORM);
        chk("f5_lows", lows, 186);

        vs_fall_now();
        chk("f6_frame", frame_lines, 24);
        chk("f6_locked", locked, 0);
        frame_rest(24, lows, lows0, st_a, st_b, st_c, st_pre, cs_mid);

        vs_fall_now();
        chk("f7_locked", locked, 1);
        frame_rest(24, lows, lows0, st_a, st_b, st_c, st_pre, cs_mid);
        chk("f7_pre", st_pre, S_PRE);

        // vsync stuck high: predicted frame overruns, fall back to unlocked.
        step(40);
        chk("stuck_pre_l24", state, S_PRE);
        chk("stuck_locked_l24", locked, 1);
        step(1);
        chk("stuck_unl", state, S_UNL);
        chk("stuck_locked", locked, 0);
        chk("stuck_frame", frame_lines, 24);
        count_low(LC, lows);
        chk("stuck_hsync", lows, 4);

        // Reset in the middle of a vsync interval.
        vs_fall_now();
        chk("pre_rst_state", state, S_VS);
        chk("pre_rst_frame", frame_lines, 27);
        step(50);
        chk("mid_vs_state", state, S_VS);
        rst = 1'b1;
        step(1);
        chk("vsrst_csync", csync, 1);
        chk("vsrst_state", state, S_UNL);
        chk("vsrst_frame", frame_lines, 0);
        chk("vsrst_locked", locked, 0);
        vsync = 1'b1;
        rst   = 1'b0;
        step(1);
        chk("post_rst_low", csync, 0);
        step(4);
        chk("post_rst_hs_end", csync, 1);
        chk("post_rst_state", state, S_UNL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/csync_sequencer.md
CSYNC_SEQUENCER -- requirements
Module: csync_sequencer

Interface
REQ-001 Parameter LINE_CLKS, default 766, clocks per scan line.
REQ-002 Parameter HSYNC_W, default 56, normal hsync low width in clocks.
REQ-003 Parameter EQ_W, default 28, equalizing pulse low width in clocks.
REQ-004 Parameter SERR_W, default 327, serration (broad) pulse low width in clocks.
REQ-005 Parameter EQ_LINES, default 3, lines of pre- and of post-equalization.
REQ-006 Parameter VS_MAX, default 8, maximum lines spent in VSYNC state.
REQ-007 Port clk  input  1  sole clock; all logic on rising edge.
REQ-008 Port rst  input  1  synchronous, active-high reset.
REQ-009 Port vsync  input  1  Atari vertical sync, active low, already synchronous to clk.
REQ-010 Port csync  output  1  composite sync, active low, registered.
REQ-011 Port locked  output  1  high while frame-length prediction is valid.
REQ-012 Port frame_lines  output  10  last measured frame length in lines.
REQ-013 Port state  output  3  current sequencer state (package encoding).

Function
REQ-014 hcnt counts 0..LINE_CLKS-1 and wraps to 0; line_cnt (10 bits, saturating at 1023) increments on every wrap.
REQ-015 vsync is registered once; a falling edge (prev 1, now 0) is "vs_fall", a rising edge is "vs_rise".
REQ-016 On vs_fall in any state except VSYNC: hcnt and line_cnt load 0 on the next cycle, frame_lines loads line_cnt+1 of the ending frame, and state becomes VSYNC.
REQ-017 vs_fall while in VSYNC is ignored (no realign, no measurement).
REQ-018 States: UNLOCKED, NORMAL, PRE_EQ, VSYNC, POST_EQ.
REQ-019 UNLOCKED: normal hsync pulses; leaves only via vs_fall.
REQ-020 VSYNC -> POST_EQ on vs_rise or when line_cnt reaches VS_MAX, whichever first, at the next line start (hcnt=0).
REQ-021 POST_EQ -> NORMAL after EQ_LINES complete lines.
REQ-022 locked sets when two consecutive measurements are equal and in range 16..1023; clears on any mismatch or out-of-range measurement; entering UNLOCKED-equivalent behaviour means NORMAL without prediction.
REQ-023 NORMAL with locked=1 -> PRE_EQ at hcnt=0 of line frame_lines-EQ_LINES.
REQ-024 PRE_EQ -> VSYNC on vs_fall; if line_cnt reaches frame_lines+1 without vs_fall, locked clears and state -> UNLOCKED.
REQ-025 NORMAL with locked=0 stays NORMAL until vs_fall (no pre-equalization emitted).
REQ-026 Pulse shapes, half = LINE_CLKS/2: NORMAL/UNLOCKED low for hcnt<HSYNC_W; PRE_EQ/POST_EQ low for hcnt<EQ_W or half<=hcnt<half+EQ_W; VSYNC low for hcnt<SERR_W or half<=hcnt<half+SERR_W.
REQ-027 csync reflects (state, hcnt) of the previous cycle: exactly one clock latency.
REQ-028 vs_fall realigns mid-line: the truncated line's pulse is abandoned and the VSYNC broad pulse starts with hcnt=0 one clock later.
REQ-029 Measurement at the first vs_fall after reset is discarded (no prior reference), frame_lines stays 0.

Reset
REQ-030 On rst: state=UNLOCKED, hcnt=0, line_cnt=0, frame_lines=0, locked=0, csync=1, vsync register=1; reset mid-frame abandons the frame with no pulse glitch beyond csync forced high.

Structure
REQ-031 Package csync_pkg holds the state enum (3-bit), default timing constants and the pulse-type enum (NONE, HSYNC, EQ, SERR).
REQ-032 One sub-module csync_pulse_shaper: takes hcnt and pulse type, produces registered csync per REQ-026/027.

Verification
REQ-033 Reset, vsync=1 for 2 lines -> csync low 56 clocks at hcnt 0 each line, locked=0, state=UNLOCKED.
REQ-034 vsync high 310 lines, low 3, repeated 3 frames -> frame_lines=313, locked=1 after second full frame.
REQ-035 Locked, frame 313 -> PRE_EQ starts line 310, two 28-clock pulses per line at hcnt 0 and 383, VSYNC broad pulses 327 clocks, 3 POST_EQ lines.
REQ-036 Locked, vsync fall 5 lines early -> immediate VSYNC, locked=0 after measurement 308 mismatches 313.
REQ-037 Locked, vsync stuck high -> at line 314 state=UNLOCKED, locked=0, normal hsync continues.
REQ-038 rst asserted during VSYNC -> next cycle csync=1, state=UNLOCKED, all counters 0.
